// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
//   - Branch type encodings carried from ID/EX (br_type).
//   - Branch redirect FSM state encodings.
//   - Datapath width constants.
package mips_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int JIDX_W = 26;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_J    = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RESOLVE  = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch/jump target computation.
// Ports:
//   pc_plus4   in  XLEN    PC+4 of the branch instruction
//   offset     in  XLEN    sign-extended 16-bit immediate
//   jump_index in  JIDX_W  J-type instr_index
//   br_type    in  2       branch type (BR_* encodings)
//   target     out XLEN    PC-relative target for BEQ/BNE, region target for J
module branch_target_calc
    import mips_pipe_pkg::*;
(
    input  logic        [XLEN-1:0]   pc_plus4,
    input  logic signed [XLEN-1:0]   offset,
    input  logic        [JIDX_W-1:0] jump_index,
    input  logic        [1:0]        br_type,
    output logic        [XLEN-1:0]   target
);

    logic signed [XLEN-1:0] off_words;
    logic        [XLEN-1:0] rel_target;
    logic        [XLEN-1:0] jmp_target;

    // Word offset; the add is modulo 2^32 so a carry out simply wraps.
    assign off_words  = offset <<< 2;
    assign rel_target = pc_plus4 + $unsigned(off_words);
    assign jmp_target = {pc_plus4[XLEN-1:XLEN-4], jump_index, 2'b00};

    assign target = (br_type == BR_J) ? jmp_target : rel_target;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer for the 5-stage MIPS pipeline.
// Latches a branch descriptor from ID/EX, resolves it in one cycle, and on a
// taken branch offers the target to fetch with a valid/ready handshake while
// flushing the wrong-path instructions. Counts accepted redirects (saturating).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   br_valid, br_type   descriptor valid pulse and type (BR_* encodings)
//   rs_eq               rs == rt comparison result
//   pc_plus4, offset    PC+4 and sign-extended immediate
//   jump_index          J-type instr_index
//   redirect_ready      fetch accepts the redirect this cycle
//   stall               hold PC and IF/ID while busy
//   redirect_valid/_pc  redirect handshake and target
//   flush_if, flush_id  squash IF/ID and ID/EX on the accepting cycle
//   taken_count         accepted redirects, saturating
module branch_redirect_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic              rs_eq,
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [XLEN-1:0]   offset,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              redirect_ready,
    output logic              stall,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush_if,
    output logic              flush_id,
    output logic [CNT_W-1:0]  taken_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]        state_q;
    logic [1:0]        type_p1;
    logic              rs_eq_p1;
    logic [XLEN-1:0]   pc_plus4_p1;
    logic [XLEN-1:0]   offset_p1;
    logic [JIDX_W-1:0] jidx_p1;
    logic [XLEN-1:0]   target_p1;
    logic              taken_p1;
    logic              accept;

    branch_target_calc u_calc (
        .pc_plus4   (pc_plus4_p1),
        .offset     (offset_p1),
        .jump_index (jidx_p1),
        .br_type    (type_p1),
        .target     (target_p1)
    );

    assign taken_p1 = (type_p1 == BR_J)
                    | ((type_p1 == BR_BEQ) &  rs_eq_p1)
                    | ((type_p1 == BR_BNE) & ~rs_eq_p1);

    assign accept         = (state_q == ST_REDIRECT) & redirect_ready;
    assign stall          = (state_q != ST_IDLE);
    assign redirect_valid = (state_q == ST_REDIRECT);
    // A reset landing on the accepting cycle must not squash anything.
    assign flush_if       = accept & rst_n;
    assign flush_id       = accept & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            type_p1     <= BR_NONE;
            rs_eq_p1    <= 1'b0;
            pc_plus4_p1 <= '0;
            offset_p1   <= '0;
            jidx_p1     <= '0;
            redirect_pc <= '0;
            taken_count <= '0;
        end else begin
            case (state_q)
                // Capture: descriptor enters the resolve stage.
                ST_IDLE: begin
                    if (br_valid && (br_type != BR_NONE)) begin
                        type_p1     <= br_type;
                        rs_eq_p1    <= rs_eq;
                        pc_plus4_p1 <= pc_plus4;
                        offset_p1   <= offset;
                        jidx_p1     <= jump_index;
                        state_q     <= ST_RESOLVE;
                    end
                end
                // Resolve: target registered only on taken; not-taken keeps the old PC.
                ST_RESOLVE: begin
                    if (taken_p1) begin
                        redirect_pc <= target_p1;
                        state_q     <= ST_REDIRECT;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                // Redirect: hold target until fetch accepts.
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        taken_count <= sat_inc(taken_count);
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl, built with CNT_W=2 so the
// saturating counter limit is reachable.
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic [1:0]  br_type;
    logic        rs_eq;
    logic [31:0] pc_plus4;
    logic [31:0] offset;
    logic [25:0] jump_index;
    logic        redirect_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic [1:0]  taken_count;

    int total = 0;
    int bad   = 0;
    int cnt_m = 0;
    logic [31:0] last_pc = 32'h0;
    logic [31:0] held_pc;

    branch_redirect_ctrl #(.CNT_W(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_valid       (br_valid),
        .br_type        (br_type),
        .rs_eq          (rs_eq),
        .pc_plus4       (pc_plus4),
        .offset         (offset),
        .jump_index     (jump_index),
        .redirect_ready (redirect_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_if       (flush_if),
        .flush_id       (flush_id),
        .taken_count    (taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_rv"}, 32'(redirect_valid), 32'd0);
        chk({tag, "_flush"}, {30'd0, flush_if, flush_id}, 32'd0);
        chk({tag, "_pc"}, redirect_pc, last_pc);
        chk({tag, "_cnt"}, 32'(taken_count), 32'(cnt_m));
    endtask

    // Full branch with redirect_ready held high, checked cycle by cycle.
    task automatic do_branch(input string tag, input logic [1:0] t, input logic rs,
                             input logic [31:0] pc, input logic [31:0] off,
                             input logic [25:0] ji, input logic taken,
                             input logic [31:0] tgt);
        br_valid = 1'b1; br_type = t; rs_eq = rs; pc_plus4 = pc;
        offset = off; jump_index = ji; redirect_ready = 1'b1;
        step();
        br_valid = 1'b0;
        chk({tag, "_n1_stall"}, 32'(stall), 32'd1);
        chk({tag, "_n1_rv"}, 32'(redirect_valid), 32'd0);
        chk({tag, "_n1_flush"}, 32'(flush_if), 32'd0);
        step();
        if (taken) begin
            chk({tag, "_n2_rv"}, 32'(redirect_valid), 32'd1);
            chk({tag, "_n2_pc"}, redirect_pc, tgt);
            chk({tag, "_n2_stall"}, 32'(stall), 32'd1);
            chk({tag, "_n2_fif"}, 32'(flush_if), 32'd1);
            chk({tag, "_n2_fid"}, 32'(flush_id), 32'd1);
            last_pc = tgt;
            if (cnt_m < 3) cnt_m++;
            step();
        end
        idle_checks({tag, "_end"});
    endtask

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; br_type = 2'b00; rs_eq = 1'b0;
        pc_plus4 = '0; offset = '0; jump_index = '0; redirect_ready = 1'b0;
        step();
        step();
        idle_checks("reset");
        rst_n = 1'b1;
        step();

        do_branch("beq_taken", 2'b01, 1'b1, 32'h0040_0004, 32'h0000_0003, 26'h0, 1'b1, 32'h0040_0010);
        do_branch("bne_nt",    2'b10, 1'b1, 32'h0040_0020, 32'h0000_0005, 26'h0, 1'b0, 32'h0);
        do_branch("beq_nt",    2'b01, 1'b0, 32'h0000_1000, 32'h0000_0040, 26'h0, 1'b0, 32'h0);
        do_branch("bne_neg",   2'b10, 1'b0, 32'h0040_0020, 32'hFFFF_FFFE, 26'h0, 1'b1, 32'h0040_0018);
        do_branch("beq_wrap",  2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0000_0002, 26'h0, 1'b1, 32'h0000_0004);
        do_branch("jump",      2'b11, 1'b0, 32'h1000_0004, 32'h0000_0000, 26'h0100000, 1'b1, 32'h1040_0000);

        // br_type=00 with br_valid is ignored.
        br_valid = 1'b1; br_type = 2'b00;
        step();
        br_valid = 1'b0;
        idle_checks("none_type");

        // Backpressure: 3 cycles not ready, ignored descriptor in the middle.
        br_valid = 1'b1; br_type = 2'b01; rs_eq = 1'b1; pc_plus4 = 32'h0000_1000;
        offset = 32'h0000_0010; redirect_ready = 1'b0;
        step();
        br_valid = 1'b0;
        step();
        held_pc = 32'h0000_1040;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rv", 32'(redirect_valid), 32'd1);
            chk("bp_pc", redirect_pc, held_pc);
            chk("bp_stall", 32'(stall), 32'd1);
            chk("bp_flush", {30'd0, flush_if, flush_id}, 32'd0);
            if (i == 1) begin
                br_valid = 1'b1; br_type = 2'b11; pc_plus4 = 32'h2000_0000; jump_index = 26'h3;
            end
            step();
            br_valid = 1'b0;
        end
        redirect_ready = 1'b1;
        #1;
        chk("bp_acc_pc", redirect_pc, held_pc);
        chk("bp_acc_flush", {30'd0, flush_if, flush_id}, 32'd3);
        last_pc = held_pc;
        if (cnt_m < 3) cnt_m++;
        step();
        idle_checks("bp_after");
        step();
        idle_checks("bp_ignored");

        // Reset while waiting in REDIRECT.
        br_valid = 1'b1; br_type = 2'b10; rs_eq = 1'b0; pc_plus4 = 32'h0000_2000;
        offset = 32'h0000_0001; redirect_ready = 1'b0;
        step();
        br_valid = 1'b0;
        step();
        chk("rst_pre_rv", 32'(redirect_valid), 32'd1);
        chk("rst_pre_pc", redirect_pc, 32'h0000_2004);
        rst_n = 1'b0;
        step();
        cnt_m = 0;
        last_pc = 32'h0;
        idle_checks("rst_mid");
        rst_n = 1'b1;
        step();
        idle_checks("rst_release");

        // Saturation: five taken branches on a 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            do_branch("sat", 2'b11, 1'b1, 32'h3000_0000, 32'h0, 26'(k + 1), 1'b1,
                      32'h3000_0000 | (32'(k + 1) << 2));
        end
        chk("sat_final", 32'(taken_count), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
